// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl - UART receive front end.
//
// Synchronises the raw serial line, validates the start bit at its middle,
// samples each data bit at mid-bit and assembles them LSB-first. The byte is
// handed to the downstream consumer through a valid/ready handshake.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   rx         raw serial line (idle high, asynchronous to clk)
//   data_ready consumer accepts data_out on an edge where data_valid = 1
//   data_out   last received byte, bit 0 = first data bit on the line
//   data_valid data_out holds an unconsumed byte
//   frame_err  one-cycle pulse: stop bit sampled as 0
//   overrun    sticky: a byte was overwritten before being accepted
//   busy       receiver FSM is not idle
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_meta;
  logic                 rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level so that
  // leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver FSM with registered outputs. The handshake clear is applied
  // first so that a byte completing on the same edge wins over the clear,
  // which gives the "consume old, load new" behaviour with overrun = 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        // Re-check the line half a bit later to reject short glitches.
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Right shift with the new bit entering the MSB, so after the last
        // bit the first bit on the line sits in bit 0.
        DATA: begin
          if (cnt == CNT_LAST) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            cnt       <= '0;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Return to IDLE at mid stop bit so back-to-back frames are caught.
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
              if (data_valid && !data_ready) begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl - self-checking bench for uart_rx_ctrl.
//
// Frames are driven bit by bit; every frame that should produce a visible
// result pushes its expected outputs and completion cycle to a scoreboard.
// A monitor pops an entry whenever a byte is presented or frame_err pulses.
module tb_uart_rx_ctrl;

  localparam int CPB  = 8;
  localparam int DBW  = 8;
  localparam int DONE = 2 + CPB / 2 + (DBW + 1) * CPB;

  logic           clk;
  logic           rst;
  logic           rx;
  logic           data_ready;
  logic [DBW-1:0] data_out;
  logic           data_valid;
  logic           frame_err;
  logic           overrun;
  logic           busy;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    int         cycle;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int   checks    = 0;
  int   failures  = 0;
  int   cycle_cnt = 0;
  bit   abort_tx  = 0;
  int   hold_cnt;

  logic [7:0] prev_data  = '0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DBW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one frame. E0 is the first edge that captures the start bit; after
  // edge E0+e the line carries frame bit (e+1)/8 (0 start, 1..8 data, 9 stop).
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input bit push, input bit ready_at_stop,
                               input logic [7:0] exp_data, input logic exp_ovr);
    logic [9:0] frame;
    exp_t       e;
    frame = {stop_bit, data, 1'b0};
    @(posedge clk);
    #1 rx = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      if (abort_tx) break;
      #1;
      if (k == 0 && push) begin
        e.data  = exp_data;
        e.valid = stop_bit;
        e.ferr  = ~stop_bit;
        e.ovr   = exp_ovr;
        e.cycle = cycle_cnt + DONE;
        sb.push_back(e);
      end
      if (ready_at_stop && k == DONE - 1) data_ready = 1'b1;
      if (ready_at_stop && k == DONE) data_ready = 1'b0;
      rx = (k < 79) ? frame[(k + 1) / CPB] : 1'b1;
    end
    #1 rx = 1'b1;
  endtask

  task automatic pulseReady();
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    #1 data_ready = 1'b0;
  endtask

  // Monitor: a result is a frame_err pulse, a rising data_valid, or new data
  // replacing a still-pending byte.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err || (data_valid && (!prev_valid || data_out != prev_data))) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_data", data_out, mon_e.data);
          checkOutput("sb_valid", data_valid, mon_e.valid);
          checkOutput("sb_ferr", frame_err, mon_e.ferr);
          checkOutput("sb_ovr", overrun, mon_e.ovr);
          checkOutput("sb_cycle", cycle_cnt, mon_e.cycle);
        end
      end
      if (prev_ferr) checkOutput("ferr_width", frame_err, 1'b0);
    end
    prev_data  = data_out;
    prev_valid = data_valid;
    prev_ferr  = frame_err;
  end

  initial begin
    rst        = 1'b0;
    rx         = 1'b1;
    data_ready = 1'b0;
    #12;
    checkOutput("rst_data", data_out, 8'h00);
    checkOutput("rst_valid", data_valid, 1'b0);
    checkOutput("rst_ferr", frame_err, 1'b0);
    checkOutput("rst_ovr", overrun, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // Test 1: clean byte, held until a ready pulse
    applyStimulus(8'hA5, 1'b1, 1, 0, 8'hA5, 1'b0);
    hold_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (data_valid) hold_cnt++;
    end
    checkOutput("t1_hold", hold_cnt, 20);
    checkOutput("t1_data", data_out, 8'hA5);
    pulseReady();
    checkOutput("t1_valid_clr", data_valid, 1'b0);
    checkOutput("t1_ovr", overrun, 1'b0);

    // Test 2: 2-clock glitch on the line
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    hold_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) hold_cnt++;
    end
    checkOutput("t2_busy_cycles", hold_cnt, 4);
    checkOutput("t2_valid", data_valid, 1'b0);

    // Test 3: framing error keeps previous data_out
    applyStimulus(8'h3C, 1'b0, 1, 0, 8'hA5, 1'b0);
    repeat (12) @(posedge clk);
    checkOutput("t3_valid", data_valid, 1'b0);
    checkOutput("t3_data", data_out, 8'hA5);

    // Test 4: back-to-back bytes without ready -> overrun
    applyStimulus(8'h01, 1'b1, 1, 0, 8'h01, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1, 0, 8'hFF, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t4_ovr", overrun, 1'b1);
    pulseReady();
    checkOutput("t4_valid_clr", data_valid, 1'b0);
    checkOutput("t4_ovr_clr", overrun, 1'b0);

    // Test 5: reset during data bit 3, then a clean frame
    fork
      applyStimulus(8'h5A, 1'b1, 0, 0, 8'h00, 1'b0);
    join_none
    repeat (36) @(posedge clk);
    #1 checkOutput("t5_busy_pre", busy, 1'b1);
    #2 rst = 1'b0;
    abort_tx = 1;
    #1;
    checkOutput("t5_data", data_out, 8'h00);
    checkOutput("t5_valid", data_valid, 1'b0);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_ovr", overrun, 1'b0);
    checkOutput("t5_ferr", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    abort_tx = 0;
    hold_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) hold_cnt++;
    end
    checkOutput("t5_idle_busy", hold_cnt, 0);
    applyStimulus(8'h5A, 1'b1, 1, 0, 8'h5A, 1'b0);
    pulseReady();
    checkOutput("t5_valid_clr", data_valid, 1'b0);

    // Test 6: ready on the exact edge a second byte completes
    applyStimulus(8'h11, 1'b1, 1, 0, 8'h11, 1'b0);
    applyStimulus(8'h77, 1'b1, 1, 1, 8'h77, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6_data", data_out, 8'h77);
    checkOutput("t6_valid", data_valid, 1'b1);
    checkOutput("t6_ovr", overrun, 1'b0);

    repeat (4) @(posedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
